// File: rtl/udp_tx_sched_pkg.sv
// Shared types and defaults for the UDP transmit scheduler.
// Burst descriptor fields are sized by the package default widths.
package udp_sched_pkg;

    localparam int ID_W_DEF  = 4;
    localparam int CNT_W_DEF = 4;
    localparam int TMR_W     = 16;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        GAP,
        FIN
    } sched_state_e;

    typedef struct packed {
        logic [ID_W_DEF-1:0]  host;
        logic [ID_W_DEF-1:0]  dst;
        logic [CNT_W_DEF-1:0] count;
    } burst_desc_t;

endpackage

// File: rtl/udp_tx_sched_if.sv
// Request/completion handshake between the scheduler (master) and the
// UDP TX engine (slave).
interface udp_tx_sched_if #(
    parameter int ID_W  = udp_sched_pkg::ID_W_DEF,
    parameter int CNT_W = udp_sched_pkg::CNT_W_DEF
) ();

    logic             tx_req;
    logic             tx_ack;
    logic [ID_W-1:0]  tx_host;
    logic [ID_W-1:0]  tx_dst;
    logic [CNT_W-1:0] tx_seq;
    logic             tx_done;

    modport master (
        output tx_req, tx_host, tx_dst, tx_seq,
        input  tx_ack, tx_done
    );

    modport slave (
        input  tx_req, tx_host, tx_dst, tx_seq,
        output tx_ack, tx_done
    );

endinterface

// File: rtl/udp_tx_sched_gap_timer.sv
// Loadable down-counter that stops at zero; used for the inter-packet
// gap and, when enabled, the completion watchdog.
module udp_gap_timer #(
    parameter int W = 16
) (
    input  logic         m_aclk,
    input  logic         m_aresetn,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_zero,
    output logic         o_last
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge m_aclk) begin
        if (!m_aresetn) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);
    assign o_last = (r_cnt == W'(1));

endmodule

// File: rtl/udp_tx_sched.sv
// Burst scheduler for the UDP TX engine: start edge -> N request/ack/done
// transactions separated by a fixed gap. Optional watchdog: UDP_TIMEOUT_EN.
module udp_tx_sched
    import udp_sched_pkg::*;
#(
    parameter int GAP_CYCLES = 16,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int ID_W       = ID_W_DEF
`ifdef UDP_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 4096
`endif
) (
    input  logic             m_aclk,
    input  logic             m_aresetn,
    input  logic             start_udp,
    input  logic [ID_W-1:0]  host,
    input  logic [ID_W-1:0]  dst,
    input  logic [CNT_W-1:0] packet,
    udp_tx_sched_if.master   tx,
    output logic             busy,
    output logic             burst_done,
    output logic [CNT_W-1:0] sent_cnt,
    output logic             err
);

    localparam bit GAP_SKIP = (GAP_CYCLES == 1);

    sched_state_e     r_state, w_state_next;
    logic             r_start_q;
    burst_desc_t      r_desc;
    logic [CNT_W-1:0] r_seq, r_sent, w_sent_plus;
    logic             w_trigger, w_latch, w_seq_inc, w_gap_load;
    logic             w_done_ok, w_last_pkt, w_gap_zero, w_gap_last;

    assign w_trigger   = start_udp & ~r_start_q;
    assign w_done_ok   = (r_state == WAIT) & tx.tx_done;
    assign w_sent_plus = r_sent + CNT_W'(1);
    assign w_last_pkt  = (w_sent_plus == CNT_W'(r_desc.count));

    // The gap timer is loaded on the tx_done cycle, so leaving GAP as it
    // reaches its last count puts the next request GAP_CYCLES after tx_done.
    udp_gap_timer #(.W(TMR_W)) u_gap (
        .m_aclk     (m_aclk),
        .m_aresetn  (m_aresetn),
        .i_load     (w_gap_load),
        .i_load_val (TMR_W'(GAP_CYCLES - 1)),
        .i_en       (r_state == GAP),
        .o_zero     (w_gap_zero),
        .o_last     (w_gap_last)
    );

`ifdef UDP_TIMEOUT_EN
    logic w_wd_load, w_wd_zero, w_wd_last, w_timeout, r_err;

    udp_gap_timer #(.W(TMR_W)) u_wdog (
        .m_aclk     (m_aclk),
        .m_aresetn  (m_aresetn),
        .i_load     (w_wd_load),
        .i_load_val (TMR_W'(TIMEOUT_CYCLES - 1)),
        .i_en       (r_state == WAIT),
        .o_zero     (w_wd_zero),
        .o_last     (w_wd_last)
    );

    always_ff @(posedge m_aclk) begin
        if (!m_aresetn) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge m_aclk) begin
        if (!m_aresetn) begin
            r_state   <= IDLE;
            r_start_q <= 1'b0;
            r_desc    <= '0;
            r_seq     <= '0;
            r_sent    <= '0;
        end else begin
            r_state   <= w_state_next;
            r_start_q <= start_udp;
            if (w_latch) begin
                r_desc.host  <= ID_W_DEF'(host);
                r_desc.dst   <= ID_W_DEF'(dst);
                r_desc.count <= CNT_W_DEF'(packet);
                r_seq        <= '0;
                r_sent       <= '0;
            end else begin
                if (w_seq_inc) r_seq  <= r_seq + CNT_W'(1);
                if (w_done_ok) r_sent <= w_sent_plus;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        w_seq_inc    = 1'b0;
        w_gap_load   = 1'b0;
`ifdef UDP_TIMEOUT_EN
        w_wd_load    = 1'b0;
        w_timeout    = 1'b0;
`endif
        unique case (r_state)
            IDLE: begin
                if (w_trigger) begin
                    w_latch      = 1'b1;
                    w_state_next = (packet == '0) ? FIN : REQ;
                end
            end
            REQ: begin
                if (tx.tx_ack) begin
                    w_state_next = WAIT;
`ifdef UDP_TIMEOUT_EN
                    w_wd_load    = 1'b1;
`endif
                end
            end
            WAIT: begin
                if (tx.tx_done) begin
                    if (w_last_pkt) begin
                        w_state_next = FIN;
                    end else if (GAP_SKIP) begin
                        w_state_next = REQ;
                        w_seq_inc    = 1'b1;
                    end else begin
                        w_state_next = GAP;
                        w_gap_load   = 1'b1;
                    end
                end
`ifdef UDP_TIMEOUT_EN
                else if (w_wd_zero) begin
                    w_timeout    = 1'b1;
                    w_state_next = FIN;
                end
`endif
            end
            GAP: begin
                if (w_gap_last | w_gap_zero) begin
                    w_state_next = REQ;
                    w_seq_inc    = 1'b1;
                end
            end
            FIN:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    assign tx.tx_req   = (r_state == REQ);
    assign tx.tx_host  = ID_W'(r_desc.host);
    assign tx.tx_dst   = ID_W'(r_desc.dst);
    assign tx.tx_seq   = r_seq;
    assign busy        = (r_state != IDLE);
    assign burst_done  = (r_state == FIN);
    assign sent_cnt    = r_sent;

endmodule
